local_injection_arbiter: RTL and testbench

//  Round-robin arbiter that shares one router Local input port between numReq PE traffic sources.

---
 rtl/local_injection_arbiter.sv | 102 ++++++++++
 tb/tb_local_injection_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/local_injection_arbiter.sv
// Round-robin arbiter sharing one router Local input port between numReq PE sources.
// The winner's packet is latched, handed to the router with Req/Gnt, then acknowledged with a one-cycle GntOut.
module local_injection_arbiter #(
  parameter int numReq    = 4,
  parameter int idxWidth  = 2,
  parameter int dataWidth = 32
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [numReq-1:0]           ReqIn,
  input  logic [numReq*dataWidth-1:0] PacketIn,
  output logic [numReq-1:0]           GntOut,
  output logic                        ReqDnStr,
  output logic [dataWidth-1:0]        PacketOut,
  input  logic                        DnStrFull,
  input  logic                        GntDnStr,
  output logic [idxWidth-1:0]         WinnerIdx,
  output logic [31:0]                 PktCount
);

  typedef enum logic [1:0] {IDLE, SEND, ACK} stateT;

  localparam logic [idxWidth:0]   numReqW  = (idxWidth + 1)'(numReq);
  localparam logic [idxWidth-1:0] ptrReset = idxWidth'(numReq - 1);
  localparam logic [numReq-1:0]   gntOne   = numReq'(1);

  stateT               state;
  logic [idxWidth-1:0] ptr;
  logic [idxWidth-1:0] pickIdx;
  logic                pickValid;
  logic [idxWidth:0]   candSum;
  logic [dataWidth-1:0] srcPacket [numReq];

  generate
    for (genvar gi = 0; gi < numReq; gi++) begin : gSplit
      assign srcPacket[gi] = PacketIn[gi*dataWidth +: dataWidth];
    end
  endgenerate

  // Scan from the farthest candidate down so the one nearest ptr+1 is assigned last and wins.
  always_comb begin
    pickValid = 1'b0;
    pickIdx   = '0;
    candSum   = '0;
    for (int k = numReq; k >= 1; k--) begin
      candSum = {1'b0, ptr} + (idxWidth + 1)'(k);
      if (candSum >= numReqW) begin
        candSum = candSum - numReqW;
      end
      if (ReqIn[candSum[idxWidth-1:0]]) begin
        pickValid = 1'b1;
        pickIdx   = candSum[idxWidth-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      ptr       <= ptrReset;
      GntOut    <= '0;
      ReqDnStr  <= 1'b0;
      PacketOut <= '0;
      WinnerIdx <= '0;
      PktCount  <= '0;
    end else begin
      case (state)
        IDLE: begin
          GntOut <= '0;
          if (!DnStrFull && pickValid) begin
            PacketOut <= srcPacket[pickIdx];
            WinnerIdx <= pickIdx;
            ReqDnStr  <= 1'b1;
            state     <= SEND;
          end else begin
            ReqDnStr <= 1'b0;
          end
        end
        SEND: begin
          // Packet is already latched; source ReqIn and DnStrFull no longer matter.
          if (GntDnStr) begin
            ReqDnStr <= 1'b0;
            GntOut   <= gntOne << WinnerIdx;
            ptr      <= WinnerIdx;
            PktCount <= PktCount + 32'd1;
            state    <= ACK;
          end
        end
        ACK: begin
          GntOut <= '0;
          state  <= IDLE;
        end
        default: begin
          GntOut   <= '0;
          ReqDnStr <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_local_injection_arbiter.sv
// Bench for local_injection_arbiter: directed vector table, hand sequences, and a random run
// compared each cycle against a transaction-level round-robin model.
module tb_local_injection_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   ReqIn;
  logic [127:0] PacketIn;
  logic [3:0]   GntOut;
  logic         ReqDnStr;
  logic [31:0]  PacketOut;
  logic         DnStrFull;
  logic         GntDnStr;
  logic [1:0]   WinnerIdx;
  logic [31:0]  PktCount;

  int checks = 0;
  int errors = 0;

  local_injection_arbiter #(.numReq(4), .idxWidth(2), .dataWidth(32)) dut (
    .clk(clk), .reset(reset), .ReqIn(ReqIn), .PacketIn(PacketIn), .GntOut(GntOut),
    .ReqDnStr(ReqDnStr), .PacketOut(PacketOut), .DnStrFull(DnStrFull), .GntDnStr(GntDnStr),
    .WinnerIdx(WinnerIdx), .PktCount(PktCount)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  req;
    logic        full;
    logic        gnt;
    logic        expReq;
    logic [3:0]  expGnt;
    logic [1:0]  expWin;
    logic [31:0] expPkt;
    logic [31:0] expCnt;
  } vecT;

  vecT vecs [18];

  // Behavioural reference: who owns the port, which source, how many delivered.
  int          mPtr;
  int          mWin;
  int          mCount;
  bit          mBusy;
  bit          mAck;
  logic [31:0] mPkt;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int rrPick(input int ptrV, input logic [3:0] req);
    for (int k = 1; k <= 4; k++) begin
      if (req[(ptrV + k) % 4]) return (ptrV + k) % 4;
    end
    return -1;
  endfunction

  function automatic logic [127:0] fixedPackets();
    logic [127:0] p;
    for (int i = 0; i < 4; i++) p[i*32 +: 32] = 32'hA5A5_0001 + 32'(i);
    return p;
  endfunction

  task automatic modelReset();
    mPtr = 3; mWin = 0; mCount = 0; mBusy = 0; mAck = 0; mPkt = 32'h0;
  endtask

  task automatic modelStep(input logic [3:0] req, input logic full, input logic gnt, input logic [127:0] pkts);
    int w;
    if (mAck) begin
      mAck = 0;
    end else if (mBusy) begin
      if (gnt) begin
        mBusy = 0; mAck = 1; mPtr = mWin; mCount = mCount + 1;
      end
    end else if (!full && req != 4'b0) begin
      w = rrPick(mPtr, req);
      mWin = w; mPkt = pkts[w*32 +: 32]; mBusy = 1;
    end
  endtask

  task automatic doReset();
    reset = 1'b0;
    #1;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int nGrants;
    int lastCyc;
    logic [3:0] dropMask;
    logic [3:0] expG;

    reset = 1'b0; ReqIn = 4'b0; PacketIn = fixedPackets(); DnStrFull = 1'b0; GntDnStr = 1'b0;
    #1;
    check("reset_reqdnstr", 64'(ReqDnStr), 64'd0);
    check("reset_gntout", 64'(GntOut), 64'd0);
    check("reset_packetout", 64'(PacketOut), 64'd0);
    check("reset_winner", 64'(WinnerIdx), 64'd0);
    check("reset_pktcount", 64'(PktCount), 64'd0);
    tick(); tick();
    reset = 1'b1;

    vecs[0]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd2, 32'hA5A5_0003, 32'd0};
    vecs[1]  = '{4'b0100, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd2, 32'hA5A5_0003, 32'd0};
    vecs[2]  = '{4'b0100, 1'b0, 1'b1, 1'b0, 4'b0100, 2'd2, 32'hA5A5_0003, 32'd1};
    vecs[3]  = '{4'b0000, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd2, 32'hA5A5_0003, 32'd1};
    vecs[4]  = '{4'b0010, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd1, 32'hA5A5_0002, 32'd1};
    vecs[5]  = '{4'b0010, 1'b0, 1'b1, 1'b0, 4'b0010, 2'd1, 32'hA5A5_0002, 32'd2};
    vecs[6]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd1, 32'hA5A5_0002, 32'd2};
    vecs[7]  = '{4'b1010, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd3, 32'hA5A5_0004, 32'd2};
    vecs[8]  = '{4'b1010, 1'b0, 1'b1, 1'b0, 4'b1000, 2'd3, 32'hA5A5_0004, 32'd3};
    vecs[9]  = '{4'b1010, 1'b0, 1'b0, 1'b0, 4'b0000, 2'd3, 32'hA5A5_0004, 32'd3};
    vecs[10] = '{4'b1010, 1'b1, 1'b0, 1'b0, 4'b0000, 2'd3, 32'hA5A5_0004, 32'd3};
    vecs[11] = '{4'b1010, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd1, 32'hA5A5_0002, 32'd3};
    vecs[12] = '{4'b0000, 1'b1, 1'b0, 1'b1, 4'b0000, 2'd1, 32'hA5A5_0002, 32'd3};
    vecs[13] = '{4'b0000, 1'b1, 1'b1, 1'b0, 4'b0010, 2'd1, 32'hA5A5_0002, 32'd4};
    vecs[14] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd1, 32'hA5A5_0002, 32'd4};
    vecs[15] = '{4'b0000, 1'b0, 1'b1, 1'b0, 4'b0000, 2'd1, 32'hA5A5_0002, 32'd4};
    vecs[16] = '{4'b0001, 1'b0, 1'b1, 1'b1, 4'b0000, 2'd0, 32'hA5A5_0001, 32'd4};
    vecs[17] = '{4'b0001, 1'b0, 1'b0, 1'b1, 4'b0000, 2'd0, 32'hA5A5_0001, 32'd4};

    for (int v = 0; v < 18; v++) begin
      ReqIn = vecs[v].req; DnStrFull = vecs[v].full; GntDnStr = vecs[v].gnt;
      tick();
      $display("vec %0d: req=%b full=%b gnt=%b -> ReqDnStr=%b GntOut=%b Winner=%0d Pkt=%h Cnt=%0d",
               v, vecs[v].req, vecs[v].full, vecs[v].gnt, ReqDnStr, GntOut, WinnerIdx, PacketOut, PktCount);
      check($sformatf("vec%0d_reqdnstr", v), 64'(ReqDnStr), 64'(vecs[v].expReq));
      check($sformatf("vec%0d_gntout", v), 64'(GntOut), 64'(vecs[v].expGnt));
      check($sformatf("vec%0d_winner", v), 64'(WinnerIdx), 64'(vecs[v].expWin));
      check($sformatf("vec%0d_packet", v), 64'(PacketOut), 64'(vecs[v].expPkt));
      check($sformatf("vec%0d_count", v), 64'(PktCount), 64'(vecs[v].expCnt));
    end

    // Reset while a packet is in flight, with five packets already counted.
    ReqIn = 4'b0000; GntDnStr = 1'b1; tick();
    check("t5_count5", 64'(PktCount), 64'd5);
    GntDnStr = 1'b0; tick();
    ReqIn = 4'b0001; tick();
    check("t5_in_send", 64'(ReqDnStr), 64'd1);
    #1 reset = 1'b0;
    #1;
    check("t5_async_reqdnstr", 64'(ReqDnStr), 64'd0);
    check("t5_async_count", 64'(PktCount), 64'd0);
    check("t5_async_packet", 64'(PacketOut), 64'd0);
    tick();
    #1 reset = 1'b1;
    ReqIn = 4'b1001; tick();
    $display("t5: after reset ReqIn=1001 -> Winner=%0d ReqDnStr=%b", WinnerIdx, ReqDnStr);
    check("t5_winner", 64'(WinnerIdx), 64'd0);
    check("t5_reqdnstr", 64'(ReqDnStr), 64'd1);
    ReqIn = 4'b0000; GntDnStr = 1'b1; tick();
    GntDnStr = 1'b0; tick();

    // Router full blocks arbitration for ten cycles.
    ReqIn = 4'b0001; DnStrFull = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      check($sformatf("t3_blocked%0d", c), 64'(ReqDnStr), 64'd0);
    end
    DnStrFull = 1'b0; tick();
    $display("t3: full released -> ReqDnStr=%b Winner=%0d", ReqDnStr, WinnerIdx);
    check("t3_release", 64'(ReqDnStr), 64'd1);
    ReqIn = 4'b0000; GntDnStr = 1'b1; tick();
    GntDnStr = 1'b0; tick();

    // All sources busy, router grants at once: strict rotation, one packet per three cycles.
    doReset();
    GntDnStr = 1'b1; dropMask = 4'b0; nGrants = 0; lastCyc = -1;
    for (int cyc = 0; cyc < 40 && nGrants < 5; cyc++) begin
      ReqIn = 4'b1111 & ~dropMask;
      tick();
      dropMask = GntOut;
      if (GntOut != 4'b0) begin
        expG = 4'b0001 << (nGrants % 4);
        $display("t2: grant %0d at cycle %0d GntOut=%b", nGrants, cyc, GntOut);
        check($sformatf("t2_grant%0d", nGrants), 64'(GntOut), 64'(expG));
        if (nGrants > 0) check($sformatf("t2_spacing%0d", nGrants), 64'(cyc - lastCyc), 64'd3);
        lastCyc = cyc;
        nGrants++;
      end
    end
    check("t2_grant_total", 64'(nGrants), 64'd5);
    GntDnStr = 1'b0; ReqIn = 4'b0;

    // Random traffic against the reference model.
    doReset();
    modelReset();
    for (int c = 0; c < 400; c++) begin
      ReqIn     = 4'($urandom_range(0, 15));
      DnStrFull = ($urandom_range(0, 3) == 0);
      GntDnStr  = ($urandom_range(0, 2) == 0);
      PacketIn  = {$urandom, $urandom, $urandom, $urandom};
      modelStep(ReqIn, DnStrFull, GntDnStr, PacketIn);
      tick();
      expG = mAck ? (4'b0001 << mWin) : 4'b0000;
      if (mAck) $display("rand %0d: delivered #%0d from source %0d packet %h", c, mCount, mWin, mPkt);
      check("rand_reqdnstr", 64'(ReqDnStr), 64'(mBusy));
      check("rand_gntout", 64'(GntOut), 64'(expG));
      check("rand_winner", 64'(WinnerIdx), 64'(mWin));
      check("rand_packet", 64'(PacketOut), 64'(mPkt));
      check("rand_count", 64'(PktCount), 64'(mCount));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
